// File: rtl/life_scan_writer.sv
// ---------------------------------------------------------------------------
// life_scan_writer
//
// Owns the Game of Life board and computes one generation per start request.
// The board is scanned serially: a rotating window register (data) and a scan
// index (cnt) feed an external neighbour-tap block, which returns the centre
// cell and its eight neighbours combinationally. The B3/S23 rule is applied
// to those bits and the result is shifted into a next-generation register,
// which is committed to the board when the scan completes.
//
// Sequence per generation: IDLE -> PRIME (1) -> SCAN (X*Y) -> COMMIT (1) -> IDLE
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   load_en          load board from load_data (IDLE only, wins over start)
//   load_data        new board, bit i = cell (y*X + x)
//   start            request one generation (IDLE only)
//   busy             high in PRIME, SCAN and COMMIT
//   done             one-cycle pulse in the cycle the new board is visible
//   board            current generation, bit i = cell i
//   data             window register to the tap (cell cnt at the MSB)
//   cnt              scan index to the tap; x = low LOG2X bits, y = high bits
//   c,l,r,u,d,
//   lu,ld,ru,rd      centre and neighbour bits returned by the tap
//   stable, extinct  (LIFE_STILL_DETECT_EN only) registered at COMMIT:
//                    new board equals old board / new board is empty
//
// Optional feature macro: LIFE_STILL_DETECT_EN
// ---------------------------------------------------------------------------
module life_scan_writer #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [X*Y-1:0]         load_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [X*Y-1:0]         board,
    output logic [X*Y-1:0]         data,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    input  logic                   c,
    input  logic                   l,
    input  logic                   r,
    input  logic                   u,
    input  logic                   d,
    input  logic                   lu,
    input  logic                   ld,
    input  logic                   ru,
    input  logic                   rd
`ifdef LIFE_STILL_DETECT_EN
    ,
    output logic                   stable,
    output logic                   extinct
`endif
);

    localparam int CELLS = X * Y;
    localparam int CW    = LOG2X + LOG2Y;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SCAN,
        COMMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CELLS-1:0] nxt_gen;
    logic [3:0]       n;
    logic             alive;
    logic             scan_last;

    // Live-neighbour count; the tap has already zeroed off-board neighbours.
    assign n = 4'(l) + 4'(r) + 4'(u) + 4'(d) + 4'(lu) + 4'(ld) + 4'(ru) + 4'(rd);
    assign alive     = (n == 4'd3) || (c && (n == 4'd2));
    assign scan_last = (cnt == CW'(CELLS - 1));
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start && !load_en) state_nxt = PRIME;
            PRIME:   state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            board   <= '0;
            data    <= '0;
            nxt_gen <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            // done lands in the first IDLE cycle, together with the new board.
            done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (load_en) board <= load_data;
                end
                PRIME: begin
                    // Pre-rotate so cell 0 sits at the MSB and cell 1 at bit 0.
                    data <= {board[0], board[CELLS-1:1]};
                    cnt  <= '0;
                end
                SCAN: begin
                    // After CELLS shifts the first result has reached bit 0.
                    nxt_gen <= {alive, nxt_gen[CELLS-1:1]};
                    data    <= {data[0], data[CELLS-1:1]};
                    cnt     <= cnt + CW'(1);
                end
                COMMIT: begin
                    board <= nxt_gen;
                end
                default: ;
            endcase
        end
    end

`ifdef LIFE_STILL_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stable  <= 1'b0;
            extinct <= 1'b0;
        end else if (state == IDLE && load_en) begin
            stable  <= 1'b0;
            extinct <= 1'b0;
        end else if (state == COMMIT) begin
            stable  <= (nxt_gen == board);
            extinct <= (nxt_gen == '0);
        end
    end
`endif

endmodule
